// File: rtl/stcu_stk_spill_ram.sv
// Branch-stack spill RAM: single-port array fronted by a 2-entry write buffer with
// read-priority arbitration, read forwarding from the buffer and a fixed 2-cycle read latency.
module stcu_stk_spill_ram #(
  parameter int unsigned DW    = 98,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH > 2 ? DEPTH : 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_rdy,
  input  logic          rd_vld,
  input  logic [AW-1:0] rd_adr,
  output logic          rd_rdy,
  output logic          rd_ack,
  output logic [DW-1:0] rd_dat,
  output logic          idle,
  output logic          err_oob
);

  localparam bit HasOob = (DEPTH < (1 << AW));

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_rd_q;

  // Write buffer: slot 0 is the head (oldest entry).
  logic [AW-1:0] buf_adr_q [2];
  logic [AW-1:0] buf_adr_d [2];
  logic [DW-1:0] buf_dat_q [2];
  logic [DW-1:0] buf_dat_d [2];
  logic [1:0]    cnt_q, cnt_d;

  logic          gnt_q;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_oob_q, s1_oob_d;
  logic          s1_fwd_q, s1_fwd_d;
  logic [DW-1:0] s1_fwd_dat_q, s1_fwd_dat_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rd_dat_q, rd_dat_d;
  logic          err_oob_q, err_oob_d;

  logic wr_oob, rd_oob;
  logic wr_acc, rd_acc, push, drain;
  logic match0, match1;

  if (HasOob) begin : g_oob
    assign wr_oob = (32'(wr_adr) >= DEPTH);
    assign rd_oob = (32'(rd_adr) >= DEPTH);
  end else begin : g_no_oob
    assign wr_oob = 1'b0;
    assign rd_oob = 1'b0;
  end

  assign wr_rdy = !clear && (cnt_q != 2'd2);
  // Withhold one read slot when full after a granted read so the head can drain.
  assign rd_rdy = !clear && !((cnt_q == 2'd2) && gnt_q);
  assign wr_acc = wr_vld && wr_rdy;
  assign rd_acc = rd_vld && rd_rdy;
  // Out-of-range writes are accepted but never enter the buffer.
  assign push   = wr_acc && !wr_oob;
  assign drain  = !clear && !rd_acc && (cnt_q != 2'd0);

  assign match0 = (cnt_q != 2'd0) && (buf_adr_q[0] == rd_adr);
  assign match1 = (cnt_q == 2'd2) && (buf_adr_q[1] == rd_adr);

  always_comb begin
    buf_adr_d = buf_adr_q;
    buf_dat_d = buf_dat_q;
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else begin
      if (drain) begin
        buf_adr_d[0] = buf_adr_q[1];
        buf_dat_d[0] = buf_dat_q[1];
      end
      if (push) begin
        if ((cnt_q == 2'd1) && !drain) begin
          buf_adr_d[1] = wr_adr;
          buf_dat_d[1] = wr_dat;
        end else begin
          buf_adr_d[0] = wr_adr;
          buf_dat_d[0] = wr_dat;
        end
      end
      cnt_d = cnt_q + 2'(push) - 2'(drain);
    end
  end

  always_comb begin
    s1_vld_d     = rd_acc && !clear;
    s1_oob_d     = rd_oob;
    s1_fwd_d     = (match0 || match1) && !rd_oob;
    s1_fwd_dat_d = match1 ? buf_dat_q[1] : buf_dat_q[0];
    ack_d        = s1_vld_q && !clear;
    rd_dat_d     = rd_dat_q;
    if (ack_d) begin
      if (s1_oob_q) begin
        rd_dat_d = '0;
      end else if (s1_fwd_q) begin
        rd_dat_d = s1_fwd_dat_q;
      end else begin
        rd_dat_d = ram_rd_q;
      end
    end
    err_oob_d = clear ? 1'b0
                      : (err_oob_q || (wr_acc && wr_oob) || (rd_acc && rd_oob));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_adr_q[i] <= '0;
        buf_dat_q[i] <= '0;
      end
      cnt_q        <= 2'd0;
      gnt_q        <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_oob_q     <= 1'b0;
      s1_fwd_q     <= 1'b0;
      s1_fwd_dat_q <= '0;
      ack_q        <= 1'b0;
      rd_dat_q     <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      buf_adr_q    <= buf_adr_d;
      buf_dat_q    <= buf_dat_d;
      cnt_q        <= cnt_d;
      gnt_q        <= rd_acc;
      s1_vld_q     <= s1_vld_d;
      s1_oob_q     <= s1_oob_d;
      s1_fwd_q     <= s1_fwd_d;
      s1_fwd_dat_q <= s1_fwd_dat_d;
      ack_q        <= ack_d;
      rd_dat_q     <= rd_dat_d;
      err_oob_q    <= err_oob_d;
    end
  end

  // Single port: a drain and a read are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[buf_adr_q[0]] <= buf_dat_q[0];
    end else if (rd_acc && !rd_oob) begin
      ram_rd_q <= mem[rd_adr];
    end
  end

  assign rd_ack  = ack_q;
  assign rd_dat  = rd_dat_q;
  assign idle    = (cnt_q == 2'd0) && !s1_vld_q && !ack_q;
  assign err_oob = err_oob_q;

endmodule

// File: tb/tb_stcu_stk_spill_ram.sv
// Directed bench for stcu_stk_spill_ram: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge of the same cycle.
module tb_stcu_stk_spill_ram;

  localparam int unsigned DW    = 98;
  localparam int unsigned DEPTH = 24;
  localparam int unsigned AW    = 5;

  localparam logic [DW-1:0] DatA  = 98'h2_1234_5678_9abc_def0_1122_3344;
  localparam logic [DW-1:0] DatB  = 98'h1_0bad_cafe_0000_1111_2222_3333;
  localparam logic [DW-1:0] DatC  = 98'h3_ffff_0000_aaaa_5555_0f0f_f0f0;
  localparam logic [DW-1:0] DatD0 = 98'h0_0000_0000_0000_0000_0000_d000;
  localparam logic [DW-1:0] DatD1 = 98'h0_0000_0000_0000_0000_0000_d111;
  localparam logic [DW-1:0] DatD2 = 98'h0_0000_0000_0000_0000_0000_d222;
  localparam logic [DW-1:0] DatD3 = 98'h0_0000_0000_0000_0000_0000_d333;
  localparam logic [DW-1:0] DatE0 = 98'h0_0000_0000_0000_0000_0000_e000;
  localparam logic [DW-1:0] DatE1 = 98'h0_0000_0000_0000_0000_0000_e111;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clear  = 1'b0;
  logic          wr_vld = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [DW-1:0] wr_dat = '0;
  logic          rd_vld = 1'b0;
  logic [AW-1:0] rd_adr = '0;
  logic          wr_rdy, rd_rdy, rd_ack, idle, err_oob;
  logic [DW-1:0] rd_dat;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stcu_stk_spill_ram #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .wr_vld (wr_vld),
    .wr_adr (wr_adr),
    .wr_dat (wr_dat),
    .wr_rdy (wr_rdy),
    .rd_vld (rd_vld),
    .rd_adr (rd_adr),
    .rd_rdy (rd_rdy),
    .rd_ack (rd_ack),
    .rd_dat (rd_dat),
    .idle   (idle),
    .err_oob(err_oob)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_vld = 1'b0;
    rd_vld = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_vld = 1'b1;
    wr_adr = a;
    wr_dat = d;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_vld = 1'b1;
    rd_adr = a;
  endtask

  initial begin
    // Reset values while held and just after release
    #2;
    chk("rst_wr_rdy", 128'(wr_rdy), 128'd1);
    chk("rst_rd_rdy", 128'(rd_rdy), 128'd1);
    chk("rst_rd_ack", 128'(rd_ack), 128'd0);
    chk("rst_rd_dat", 128'(rd_dat), 128'd0);
    chk("rst_idle", 128'(idle), 128'd1);
    chk("rst_err_oob", 128'(err_oob), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    chk("rel_wr_rdy", 128'(wr_rdy), 128'd1);
    chk("rel_rd_rdy", 128'(rd_rdy), 128'd1);
    chk("rel_idle", 128'(idle), 128'd1);
    chk("rel_rd_ack", 128'(rd_ack), 128'd0);

    // Write then read of the same address, latency 2
    tick(); wr(5'd5, DatA);
    mid(); chk("t1_wr_rdy", 128'(wr_rdy), 128'd1);
    tick(); quiet(); rd(5'd5);
    mid(); chk("t1_rd_rdy", 128'(rd_rdy), 128'd1);
    tick(); quiet();
    mid(); chk("t1_ack_n1", 128'(rd_ack), 128'd0);
    tick();
    mid(); chk("t1_ack_n2", 128'(rd_ack), 128'd1);
    chk("t1_dat", 128'(rd_dat), 128'(DatA));
    tick();
    mid(); chk("t1_ack_n3", 128'(rd_ack), 128'd0);
    chk("t1_dat_hold", 128'(rd_dat), 128'(DatA));
    chk("t1_idle", 128'(idle), 128'd1);

    // Same-cycle write and read: read-first
    tick(); wr(5'd3, DatC);
    tick(); quiet();
    tick(); wr(5'd3, DatB); rd(5'd3);
    mid(); chk("t2_wr_rdy", 128'(wr_rdy), 128'd1);
    chk("t2_rd_rdy", 128'(rd_rdy), 128'd1);
    tick(); quiet();
    tick();
    mid(); chk("t2_ack_old", 128'(rd_ack), 128'd1);
    chk("t2_dat_old", 128'(rd_dat), 128'(DatC));
    tick(); rd(5'd3);
    tick(); quiet();
    tick();
    mid(); chk("t2_ack_new", 128'(rd_ack), 128'd1);
    chk("t2_dat_new", 128'(rd_dat), 128'(DatB));

    // Continuous reads against a full buffer
    tick(); rd(5'd5); wr(5'd10, DatD0);
    mid(); chk("t3_rdy_a0", 128'(rd_rdy), 128'd1);
    tick(); wr(5'd11, DatD1);
    mid(); chk("t3_rdy_a1", 128'(rd_rdy), 128'd1);
    tick(); wr(5'd12, DatD2);
    mid(); chk("t3_rdy_a2", 128'(rd_rdy), 128'd0);
    chk("t3_wrdy_a2", 128'(wr_rdy), 128'd0);
    tick();
    mid(); chk("t3_rdy_a3", 128'(rd_rdy), 128'd1);
    chk("t3_wrdy_a3", 128'(wr_rdy), 128'd1);
    tick(); wr(5'd13, DatD3);
    mid(); chk("t3_rdy_a4", 128'(rd_rdy), 128'd0);
    tick();
    mid(); chk("t3_rdy_a5", 128'(rd_rdy), 128'd1);
    tick(); wr_vld = 1'b0;
    mid(); chk("t3_rdy_a6", 128'(rd_rdy), 128'd0);
    tick();
    mid(); chk("t3_rdy_a7", 128'(rd_rdy), 128'd1);
    tick(); quiet();
    tick();
    tick();
    mid(); chk("t3_idle", 128'(idle), 128'd1);
    tick(); rd(5'd10);
    tick(); rd(5'd11);
    tick(); rd(5'd12);
    mid(); chk("t3_rb_ack0", 128'(rd_ack), 128'd1);
    chk("t3_rb_dat10", 128'(rd_dat), 128'(DatD0));
    tick(); rd(5'd13);
    mid(); chk("t3_rb_dat11", 128'(rd_dat), 128'(DatD1));
    tick(); quiet();
    mid(); chk("t3_rb_dat12", 128'(rd_dat), 128'(DatD2));
    tick();
    mid(); chk("t3_rb_ack3", 128'(rd_ack), 128'd1);
    chk("t3_rb_dat13", 128'(rd_dat), 128'(DatD3));
    tick();
    mid(); chk("t3_rb_end", 128'(rd_ack), 128'd0);

    // Clear cancels in-flight reads
    tick(); rd(5'd10);
    mid(); chk("t4_ack_c0", 128'(rd_ack), 128'd0);
    tick(); rd(5'd11);
    mid(); chk("t4_ack_c1", 128'(rd_ack), 128'd0);
    tick(); rd(5'd12); clear = 1'b1;
    mid(); chk("t4_rd_rdy_clr", 128'(rd_rdy), 128'd0);
    chk("t4_wr_rdy_clr", 128'(wr_rdy), 128'd0);
    chk("t4_ack_c2", 128'(rd_ack), 128'd1);
    chk("t4_dat_c2", 128'(rd_dat), 128'(DatD0));
    tick(); quiet();
    mid(); chk("t4_ack_c3", 128'(rd_ack), 128'd0);
    chk("t4_idle_c3", 128'(idle), 128'd1);
    tick();
    mid(); chk("t4_ack_c4", 128'(rd_ack), 128'd0);

    // Out-of-range write and read (DEPTH=24)
    tick(); wr(5'd25, DatE0);
    mid(); chk("t5_wr_rdy", 128'(wr_rdy), 128'd1);
    chk("t5_err_pre", 128'(err_oob), 128'd0);
    tick(); quiet();
    mid(); chk("t5_err_wr", 128'(err_oob), 128'd1);
    chk("t5_idle_drop", 128'(idle), 128'd1);
    tick(); clear = 1'b1;
    tick(); quiet();
    mid(); chk("t5_err_clr1", 128'(err_oob), 128'd0);
    tick(); rd(5'd30);
    mid(); chk("t5_err_rd_pre", 128'(err_oob), 128'd0);
    tick(); quiet();
    mid(); chk("t5_err_rd", 128'(err_oob), 128'd1);
    tick();
    mid(); chk("t5_oob_ack", 128'(rd_ack), 128'd1);
    chk("t5_oob_dat", 128'(rd_dat), 128'd0);
    tick(); clear = 1'b1;
    tick(); quiet();
    mid(); chk("t5_err_clr2", 128'(err_oob), 128'd0);

    // Reset mid-operation
    tick(); wr(5'd14, DatE0); rd(5'd10);
    tick(); wr(5'd15, DatE1); rd(5'd11);
    mid(); chk("t6_busy", 128'(idle), 128'd0);
    tick(); quiet(); rst_n = 1'b0;
    mid(); chk("t6_rst_ack", 128'(rd_ack), 128'd0);
    chk("t6_rst_idle", 128'(idle), 128'd1);
    tick(); rst_n = 1'b1;
    mid(); chk("t6_rel_idle", 128'(idle), 128'd1);
    chk("t6_rel_wr_rdy", 128'(wr_rdy), 128'd1);
    chk("t6_rel_ack0", 128'(rd_ack), 128'd0);
    tick();
    mid(); chk("t6_rel_ack1", 128'(rd_ack), 128'd0);
    chk("t6_rel_idle1", 128'(idle), 128'd1);
    tick();
    mid(); chk("t6_rel_ack2", 128'(rd_ack), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/stcu_stk_spill_ram.md
STCU_STK_SPILL_RAM -- requirements
Module: stcu_stk_spill_ram

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, default 98, entry width in bits.
- DEPTH, default 32, number of array entries.
- AW, default $clog2(DEPTH>2?DEPTH:2), address width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- wr_vld  in  1  write request from the branch stack.
- wr_adr  in  AW  write address.
- wr_dat  in  DW  write data.
- wr_rdy  out  1  write accepted when wr_vld&&wr_rdy.
- rd_vld  in  1  read request.
- rd_adr  in  AW  read address.
- rd_rdy  out  1  read accepted when rd_vld&&rd_rdy.
- rd_ack  out  1  one-cycle pulse, rd_dat valid.
- rd_dat  out  DW  read data.
- idle  out  1  no pending write, no read in flight.
- err_oob  out  1  sticky out-of-range address flag.
REQ-003 The block SHALL use one clock, with reset asynchronous and active-low on rst_n.

Function
REQ-004 Storage SHALL be a DEPTH x DW single-port array performing at most one access (read or write) per cycle; the array is not reset.
REQ-005 Accepted writes SHALL enter a 2-entry in-order write buffer; wr_rdy = buffer not full (combinational).
REQ-006 Arbitration per cycle SHALL be:
- Read priority: an accepted read uses the array this cycle.
- Otherwise the buffer head drains to the array at the clock edge.
REQ-007 Anti-starvation: rd_rdy SHALL be 0 in any cycle where the buffer is full and the previous cycle granted a read; rd_rdy is 1 otherwise.
REQ-008 Read latency SHALL be fixed: read accepted in cycle N -> rd_ack=1 in cycle N+2 only.
- rd_dat is updated with the returned value in cycle N+2 and holds until the next ack.
- Back-to-back reads SHALL be supported, one per cycle.
REQ-009 Forwarding SHALL apply to a read whose address matches a buffered write accepted in an earlier cycle.
- The read returns the newest matching buffered data.
- Latency is unchanged.
REQ-010 A write and a read accepted in the same cycle SHALL be ordered read-first: the read returns the pre-write value.
REQ-011 An address >= DEPTH SHALL set err_oob at the next edge.
- A write to such an address is accepted and dropped.
- A read to such an address is acked with rd_dat = 0.
REQ-012 idle SHALL = buffer empty && no read in stage N+1 or N+2.
REQ-013 clear SHALL, at the next edge, do all of the following:
- Empty the write buffer (pending writes discarded).
- Cancel in-flight reads, so no rd_ack follows.
- Clear err_oob.
- Requests presented in a clear cycle are not accepted; wr_rdy and rd_rdy are forced to 0 while clear=1.
- Array contents are unchanged.
REQ-014 With wr_vld=0, a non-empty buffer SHALL drain one entry per cycle in which no read is accepted.

Reset
REQ-015 While rst_n=0 and immediately after release, outputs SHALL be: wr_rdy=1, rd_rdy=1, rd_ack=0, rd_dat=0, idle=1, err_oob=0.
REQ-016 Reset asserted mid-operation SHALL discard the buffer and in-flight reads, with no rd_ack after release.

Verification
REQ-017 Write adr 5 dat A (cycle 0), then read adr 5 (cycle 1) -> rd_ack in cycle 3, rd_dat=A (via forwarding or array).
REQ-018 Same cycle: wr adr 3 dat B and rd adr 3, array holding C -> rd_dat=C at N+2; a later read of adr 3 returns B.
REQ-019 Continuous rd_vld with the buffer full -> rd_rdy alternates 0/1; the buffer drains; no write is lost (readback of all 4 addresses correct).
REQ-020 Reads in cycles 0,1,2 then clear in cycle 2 -> rd_ack only in cycle 2 (from the cycle-0 read); none in cycles 3-4; idle=1 in cycle 3.
REQ-021 DEPTH=24, read adr 30 -> err_oob=1 next cycle, rd_ack with rd_dat=0; clear -> err_oob=0.
REQ-022 rst_n pulsed low while 2 writes are buffered and 1 read is in flight -> after release idle=1, rd_ack stays 0, wr_rdy=1.
